// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - EX-stage multiply/divide controller owning HI/LO
module muldiv_hilo_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_ret_i,
    input  logic        div_ready_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int              DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt;
    logic          acc, is_div, div_latch;
    logic [31:0]   hi_nxt, lo_nxt;
    logic [63:0]   mul_a, mul_b, mul_p;

    assign acc    = valid_i & ~flush_i;
    assign is_div = (op_i == OP_DIV) | (op_i == OP_DIVU);

    // 64x64 truncated product of extended operands gives the exact 64-bit result
    assign mul_a = (op_i == OP_MULT) ? {{32{op1_i[31]}}, op1_i} : {32'd0, op1_i};
    assign mul_b = (op_i == OP_MULT) ? {{32{op2_i[31]}}, op2_i} : {32'd0, op2_i};
    assign mul_p = mul_a * mul_b;

    always_comb begin
        state_nxt   = state;
        stall_o     = 1'b0;
        div_annul_o = 1'b0;
        div_latch   = 1'b0;
        hi_nxt      = hi_o;
        lo_nxt      = lo_o;

        case (state)
            IDLE: begin
                if (acc && is_div) begin
                    div_latch = 1'b1;
                    stall_o   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    state_nxt   = DRAIN;
                end else if (div_ready_i) begin
                    hi_nxt    = div_ret_i[63:32];
                    lo_nxt    = div_ret_i[31:0];
                    state_nxt = DRAIN;
                end else begin
                    stall_o = 1'b1;
                end
            end
            DRAIN: begin
                if (acc && is_div)
                    stall_o = 1'b1;
                if (drain_cnt == DRAIN_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Non-divide ops run whenever no divide is outstanding
        if (acc && (state == IDLE || state == DRAIN)) begin
            case (op_i)
                OP_MULT, OP_MULTU: begin
                    hi_nxt = mul_p[63:32];
                    lo_nxt = mul_p[31:0];
                end
                OP_MTHI: hi_nxt = op1_i;
                OP_MTLO: lo_nxt = op1_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            hi_o         <= 32'd0;
            lo_o         <= 32'd0;
            div_start_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= 32'd0;
            div_op2_o    <= 32'd0;
        end else begin
            state       <= state_nxt;
            hi_o        <= hi_nxt;
            lo_o        <= lo_nxt;
            div_start_o <= (state_nxt == BUSY);
            drain_cnt   <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            // Operands stay frozen for the whole divide; the divider re-reads them
            if (div_latch) begin
                div_signed_o <= (op_i == OP_DIV);
                div_op1_o    <= op1_i;
                div_op2_o    <= op2_i;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb/tb_muldiv_hilo_ctrl.sv - directed bench for muldiv_hilo_ctrl with a 35-cycle divider model
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] op1_i = 32'd0;
    logic [31:0] op2_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic [31:0] hi_o, lo_o;
    logic        div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic [63:0] div_ret_i = 64'd0;
    logic        div_ready_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int dcnt    = 0;

    always #5 clk = ~clk;

    muldiv_hilo_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i),
        .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i), .stall_o(stall_o),
        .hi_o(hi_o), .lo_o(lo_o), .div_start_o(div_start_o),
        .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_ret_i(div_ret_i), .div_ready_i(div_ready_i)
    );

    function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = int'(a); sb = int'(b);
            q = sa / sb; r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Divider stand-in: ready rises after 34 cycles of start, i.e. 35 cycles after issue
    always @(posedge clk) begin
        if (rst || !div_start_o || div_annul_o) begin
            dcnt        <= 0;
            div_ready_i <= 1'b0;
        end else begin
            dcnt <= dcnt + 1;
            if (dcnt == 33) begin
                div_ready_i <= 1'b1;
                div_ret_i   <= div_model(div_signed_o, div_op1_o, div_op2_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic f);
        valid_i = v; op_i = op; op1_i = a; op2_i = b; flush_i = f;
    endtask

    task automatic chk_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        n_tests++;
        if (hi_o !== eh || lo_o !== el) begin
            n_fail++;
            $display("FAIL %s: hi=%h lo=%h expected hi=%h lo=%h", name, hi_o, lo_o, eh, el);
        end
    endtask

    task automatic wait_retire(input int init_cnt, input int exp_cnt, input logic [31:0] eh,
                               input logic [31:0] el, input string name);
        int cnt = init_cnt;
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (stall_o) begin
                cnt++;
                step();
            end else begin
                done = 1;
            end
        end
        n_tests++;
        if (!done || cnt != exp_cnt) begin
            n_fail++;
            $display("FAIL %s_stall: stall cycles=%0d done=%0d expected %0d", name, cnt, done, exp_cnt);
        end
        step();
        drive(0, 3'd0, 32'd0, 32'd0, 0);
        chk_hilo(name, eh, el);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (div_start_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_drain%0d: div_start_o=%b expected 0", name, i, div_start_o);
            end
            step();
        end
    endtask

    task automatic do_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        drive(1, op, a, b, 0);
        wait_retire(0, 35, eh, el, name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk_hilo("reset_hilo", 32'd0, 32'd0);
        n_tests++;
        if (stall_o !== 1'b0 || div_start_o !== 1'b0 || div_annul_o !== 1'b0 ||
            div_signed_o !== 1'b0 || div_op1_o !== 32'd0 || div_op2_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: stall=%b start=%b annul=%b sgn=%b op1=%h op2=%h expected all 0",
                     stall_o, div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o);
        end
        step();
    endtask

    task automatic mul_case(input logic [2:0] op, input logic f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                            input string name);
        drive(1, op, a, b, f);
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_stall: stall_o=%b expected 0", name, stall_o);
        end
        step();
        drive(0, 3'd0, 32'd0, 32'd0, 0);
        chk_hilo(name, eh, el);
    endtask

    task automatic test_mult();
        mul_case(3'd1, 0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        mul_case(3'd2, 0, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
        mul_case(3'd1, 1, 32'd5, 32'd5, 32'h0000_0002, 32'hFFFF_FFFA, "mult_flushed");
        mul_case(3'd7, 0, 32'd5, 32'd5, 32'h0000_0002, 32'hFFFF_FFFA, "reserved_op");
    endtask

    task automatic test_div();
        do_div(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        do_div(3'd4, 32'd100, 32'd0, 32'd0, 32'd0, "divu_by_zero");
    endtask

    task automatic test_mthi_mtlo();
        drive(1, 3'd5, 32'h1234_5678, 32'd0, 0);
        step();
        drive(1, 3'd6, 32'h9ABC_DEF0, 32'd0, 0);
        step();
        drive(0, 3'd0, 32'd0, 32'd0, 0);
        chk_hilo("mthi_mtlo", 32'h1234_5678, 32'h9ABC_DEF0);
        mul_case(3'd6, 1, 32'h1111_1111, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, "mtlo_flushed");
    endtask

    task automatic test_flush();
        drive(1, 3'd3, 32'd50, 32'd7, 0);
        for (int i = 0; i < 10; i++) step();
        n_tests++;
        if (div_annul_o !== 1'b0 || stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_flush: annul=%b stall=%b expected 0 1", div_annul_o, stall_o);
        end
        flush_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (div_annul_o !== 1'b1 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_annul: annul=%b stall=%b expected 1 0", div_annul_o, stall_o);
        end
        step();
        chk_hilo("flush_no_write", 32'h1234_5678, 32'h9ABC_DEF0);
        drive(1, 3'd3, 32'd9, 32'd4, 0);
        @(negedge clk);
        n_tests++;
        if (div_annul_o !== 1'b0 || stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_div: annul=%b stall=%b expected 0 1", div_annul_o, stall_o);
        end
        step();
        wait_retire(1, 37, 32'd1, 32'd2, "div_after_flush");
    endtask

    task automatic test_reset_mid_div();
        drive(1, 3'd3, 32'd20, 32'd6, 0);
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        drive(0, 3'd0, 32'd0, 32'd0, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b0 || div_start_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_div: stall=%b start=%b expected 0 0", stall_o, div_start_o);
        end
        chk_hilo("rst_mid_div_hilo", 32'd0, 32'd0);
        step();
        do_div(3'd3, 32'd10, 32'd3, 32'd1, 32'd3, "div_after_rst");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_flush();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
